// File: rtl/axi_stream_to_bt656.sv
// Serialises 16-bit YCbCr 4:2:2 AXI-Stream beats into a registered BT.656 byte stream (1 cycle latency).
// Line timing never stalls: missing beats become black pixels; status counters exist only with BT656_TX_CNT_EN.
module axi_stream_to_bt656 #(
    parameter int H_ACTIVE = 720,
    parameter int H_BLANK  = 268,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 45
) (
    input  logic        axi_clk_i,
    input  logic        axi_rst_i,
    input  logic        tx_enable_i,
    input  logic [15:0] s_tdata_i,
    input  logic        s_tvalid_i,
    output logic        s_tready_o,
    input  logic        s_tuser_i,
    input  logic        s_tlast_i,
    output logic [7:0]  bt656_data_o,
    output logic        bt656_href_o,
    output logic        bt656_vsync_o,
    output logic [15:0] underrun_cnt_o,
    output logic [15:0] sync_err_cnt_o,
    output logic [15:0] frame_cnt_o
);
    localparam int CW = $clog2(2 * H_ACTIVE + H_BLANK + 8);
    localparam int LW = $clog2(V_ACTIVE + V_BLANK + 1);
    localparam logic [CW-1:0] CNT_REF_END = CW'(3);
    localparam logic [CW-1:0] CNT_HB_END  = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] CNT_VID_END = CW'(2 * H_ACTIVE - 1);
    localparam logic [LW-1:0] LINE_FIRST_ACT = LW'(V_BLANK);
    localparam logic [LW-1:0] LINE_LAST = LW'(V_ACTIVE + V_BLANK - 1);

    typedef enum logic [2:0] {IDLE, EAV, HBLANK, SAV, VIDEO} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] line_q, line_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    luma_q, luma_d;
    logic          href_q, href_d;
    logic          vsync_q, vsync_d;
    logic          vblank, last_line, vid_end, act_chroma;

    function automatic logic [7:0] ref_byte(input logic [1:0] idx, input logic [7:0] xy);
        case (idx)
            2'd0:    return 8'hFF;
            2'd3:    return xy;
            default: return 8'h00;
        endcase
    endfunction

    assign vblank     = line_q < LINE_FIRST_ACT;
    assign last_line  = line_q == LINE_LAST;
    assign vid_end    = (state_q == VIDEO) && (cnt_q == CNT_VID_END);
    assign act_chroma = (state_q == VIDEO) && !vblank && !cnt_q[0];
    // In vertical blanking stale beats are flushed, but a start-of-frame beat waits at the input.
    assign s_tready_o = act_chroma || ((state_q != IDLE) && vblank && !s_tuser_i);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        line_d  = line_q;
        data_d  = 8'h00;
        href_d  = 1'b0;
        vsync_d = 1'b0;
        luma_d  = luma_q;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                line_d = '0;
                if (tx_enable_i) state_d = EAV;
            end
            EAV: begin
                data_d  = ref_byte(cnt_q[1:0], vblank ? 8'hB6 : 8'h9D);
                vsync_d = vblank;
                if (cnt_q == CNT_REF_END) begin
                    state_d = HBLANK;
                    cnt_d   = '0;
                end
            end
            HBLANK: begin
                data_d  = cnt_q[0] ? 8'h10 : 8'h80;
                vsync_d = vblank;
                if (cnt_q == CNT_HB_END) begin
                    state_d = SAV;
                    cnt_d   = '0;
                end
            end
            SAV: begin
                data_d  = ref_byte(cnt_q[1:0], vblank ? 8'hAB : 8'h80);
                vsync_d = vblank;
                if (cnt_q == CNT_REF_END) begin
                    state_d = VIDEO;
                    cnt_d   = '0;
                end
            end
            VIDEO: begin
                vsync_d = vblank;
                href_d  = !vblank;
                if (vblank) begin
                    data_d = cnt_q[0] ? 8'h10 : 8'h80;
                end else if (cnt_q[0]) begin
                    data_d = luma_q;
                end else if (s_tvalid_i) begin
                    data_d = s_tdata_i[15:8];
                    luma_d = s_tdata_i[7:0];
                end else begin
                    data_d = 8'h80;
                    luma_d = 8'h10;
                end
                if (vid_end) begin
                    cnt_d = '0;
                    if (last_line) begin
                        line_d  = '0;
                        state_d = tx_enable_i ? EAV : IDLE;
                    end else begin
                        line_d  = line_q + 1'b1;
                        state_d = EAV;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            data_q  <= 8'h00;
            luma_q  <= 8'h00;
            href_q  <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            data_q  <= data_d;
            luma_q  <= luma_d;
            href_q  <= href_d;
            vsync_q <= vsync_d;
        end
    end

    assign bt656_data_o  = data_q;
    assign bt656_href_o  = href_q;
    assign bt656_vsync_o = vsync_q;

`ifdef BT656_TX_CNT_EN
    localparam logic [CW-2:0] PIX_LAST = (CW - 1)'(H_ACTIVE - 1);

    logic [15:0]   underrun_q, underrun_d;
    logic [15:0]   sync_err_q, sync_err_d;
    logic [15:0]   frame_q, frame_d;
    logic [CW-2:0] pix;
    logic          beat_err;

    assign pix      = cnt_q[CW-1:1];
    assign beat_err = (s_tuser_i != ((line_q == LINE_FIRST_ACT) && (pix == '0)))
                   || (s_tlast_i != (pix == PIX_LAST));

    always_comb begin
        underrun_d = underrun_q;
        sync_err_d = sync_err_q;
        frame_d    = frame_q;
        if (act_chroma && !s_tvalid_i && (underrun_q != 16'hFFFF)) underrun_d = underrun_q + 16'd1;
        if (act_chroma && s_tvalid_i && beat_err && (sync_err_q != 16'hFFFF)) sync_err_d = sync_err_q + 16'd1;
        if (vid_end && last_line && (frame_q != 16'hFFFF)) frame_d = frame_q + 16'd1;
    end

    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            underrun_q <= 16'h0000;
            sync_err_q <= 16'h0000;
            frame_q    <= 16'h0000;
        end else begin
            underrun_q <= underrun_d;
            sync_err_q <= sync_err_d;
            frame_q    <= frame_d;
        end
    end

    assign underrun_cnt_o = underrun_q;
    assign sync_err_cnt_o = sync_err_q;
    assign frame_cnt_o    = frame_q;
`else
    logic unused_tlast;
    assign unused_tlast   = s_tlast_i;
    assign underrun_cnt_o = 16'h0000;
    assign sync_err_cnt_o = 16'h0000;
    assign frame_cnt_o    = 16'h0000;
`endif
endmodule

// File: tb/tb_axi_stream_to_bt656.sv
// Bench for axi_stream_to_bt656: a no-input frame from a constant table, then directed and random
// frames checked cycle by cycle against a position-based model of the BT.656 line/frame layout.
module tb_axi_stream_to_bt656;
    localparam int HA = 4;
    localparam int HB = 4;
    localparam int VA = 2;
    localparam int VB = 1;
    localparam int LL = 8 + HB + 2 * HA;
    localparam int FL = LL * (VA + VB);
`ifdef BT656_TX_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, en, tvalid, tready, tuser, tlast, href, vsync;
    logic [15:0] tdata, und, serr, fcnt;
    logic [7:0]  data;

    always #5 clk = ~clk;

    axi_stream_to_bt656 #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB)) dut (
        .axi_clk_i(clk), .axi_rst_i(rst), .tx_enable_i(en),
        .s_tdata_i(tdata), .s_tvalid_i(tvalid), .s_tready_o(tready),
        .s_tuser_i(tuser), .s_tlast_i(tlast),
        .bt656_data_o(data), .bt656_href_o(href), .bt656_vsync_o(vsync),
        .underrun_cnt_o(und), .sync_err_cnt_o(serr), .frame_cnt_o(fcnt)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- constant table for an enabled frame with no input ----------------
    typedef struct {
        logic       vld;
        logic       usr;
        logic [7:0] dat;
        logic       hrf;
        logic       vsy;
        logic       rdy;
    } vec_t;
    vec_t       tbl [FL];
    logic [7:0] blank_ln [LL] = '{8'hFF, 8'h00, 8'h00, 8'hB6, 8'h80, 8'h10, 8'h80, 8'h10, 8'hFF, 8'h00,
                                  8'h00, 8'hAB, 8'h80, 8'h10, 8'h80, 8'h10, 8'h80, 8'h10, 8'h80, 8'h10};
    logic [7:0] act_ln [LL]   = '{8'hFF, 8'h00, 8'h00, 8'h9D, 8'h80, 8'h10, 8'h80, 8'h10, 8'hFF, 8'h00,
                                  8'h00, 8'h80, 8'h80, 8'h10, 8'h80, 8'h10, 8'h80, 8'h10, 8'h80, 8'h10};

    // ---------------- reference model state ----------------
    logic [17:0] bq[$];
    int          vld_pct = 100;
    int          pos = -1;
    logic [7:0]  e_dat = 8'h00;
    logic        e_href = 1'b0;
    logic        e_vs = 1'b0;
    logic [7:0]  m_luma = 8'h00;
    int          m_und = 0;
    int          m_serr = 0;
    int          m_frm = 0;

    function automatic logic [7:0] ref_code(input int idx, input logic [7:0] xy);
        if (idx == 0) return 8'hFF;
        if (idx == 3) return xy;
        return 8'h00;
    endfunction

    task automatic drive();
        if (bq.size() > 0 && int'($urandom_range(0, 99)) < vld_pct) begin
            tvalid = 1'b1;
            {tuser, tlast, tdata} = bq[0];
        end else begin
            tvalid = 1'b0;
            tuser  = 1'b0;
            tlast  = 1'b0;
            tdata  = 16'($urandom);
        end
    endtask

    // Called at posedge+1 with this cycle's inputs driven; predicts tready now and the byte of next cycle.
    task automatic tick();
        logic [7:0] d, nl;
        logic h, v, r, u_inc, s_inc;
        int line, col, k;
        d = 8'h00; nl = m_luma; h = 1'b0; v = 1'b0; r = 1'b0; u_inc = 1'b0; s_inc = 1'b0;
        if (pos >= 0) begin
            line = pos / LL;
            col  = pos % LL;
            v    = (line < VB);
            if (col < 4) d = ref_code(col, v ? 8'hB6 : 8'h9D);
            else if (col < 4 + HB) d = ((col - 4) % 2 == 0) ? 8'h80 : 8'h10;
            else if (col < 8 + HB) d = ref_code(col - 4 - HB, v ? 8'hAB : 8'h80);
            else begin
                k = col - 8 - HB;
                if (v) d = (k % 2 == 0) ? 8'h80 : 8'h10;
                else begin
                    h = 1'b1;
                    if (k % 2 == 1) d = m_luma;
                    else begin
                        r = 1'b1;
                        if (tvalid) begin
                            d  = tdata[15:8];
                            nl = tdata[7:0];
                            s_inc = (tuser != (line == VB && k == 0)) || (tlast != (k / 2 == HA - 1));
                        end else begin
                            d  = 8'h80;
                            nl = 8'h10;
                            u_inc = 1'b1;
                        end
                    end
                end
            end
            if (v) r = !tuser;
        end
        #4;
        chk("data", data, e_dat);
        chk("href", href, e_href);
        chk("vsync", vsync, e_vs);
        chk("tready", tready, r);
        chk("underrun_cnt", und, CNT_EN ? m_und : 0);
        chk("sync_err_cnt", serr, CNT_EN ? m_serr : 0);
        chk("frame_cnt", fcnt, CNT_EN ? m_frm : 0);
        e_dat = d; e_href = h; e_vs = v; m_luma = nl;
        if (u_inc && m_und < 65535) m_und++;
        if (s_inc && m_serr < 65535) m_serr++;
        if (tvalid && r) void'(bq.pop_front());
        if (pos < 0) begin
            if (en) pos = 0;
        end else if (pos == FL - 1) begin
            if (m_frm < 65535) m_frm++;
            pos = en ? 0 : -1;
        end else pos++;
        if (rst) begin
            pos = -1; e_dat = 8'h00; e_href = 1'b0; e_vs = 1'b0;
            m_und = 0; m_serr = 0; m_frm = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive();
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_frame(input bit rnd, input int extra_last);
        for (int l = 0; l < VA; l++) begin
            for (int p = 0; p < HA; p++) begin
                int idx;
                logic [15:0] dd;
                logic u, t;
                idx = l * HA + p;
                dd  = rnd ? 16'($urandom) : {8'(8'hC1 + idx), 8'(8'h31 + idx)};
                u   = (l == 0 && p == 0);
                t   = (p == HA - 1) || (l == 0 && p == extra_last);
                bq.push_back({u, t, dd});
            end
        end
    endtask

    task automatic push_junk(input int n);
        for (int i = 0; i < n; i++) bq.push_back({1'b0, 1'b0, 16'($urandom)});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; tdata = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_data", data, 8'h00);
        chk("reset_href", href, 1'b0);
        chk("reset_vsync", vsync, 1'b0);
        chk("reset_tready", tready, 1'b0);
        chk("reset_counters", {und, serr}, 32'h0);
        chk("reset_frames", fcnt, 16'h0);

        // Enabled frame with no input: constant table
        for (int i = 0; i < FL; i++) begin
            tbl[i].vld = 1'b0;
            tbl[i].usr = 1'b0;
            tbl[i].dat = (i / LL == 0) ? blank_ln[i % LL] : act_ln[i % LL];
            tbl[i].hrf = (i / LL != 0) && (i % LL >= 8 + HB);
            tbl[i].vsy = (i / LL == 0);
            tbl[i].rdy = (i / LL == 0) ? 1'b1 : ((i % LL >= 8 + HB) && ((i % LL) % 2 == 0));
        end
        en = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < FL; i++) begin
            tvalid = tbl[i].vld;
            tuser  = tbl[i].usr;
            if (i == FL - 1) en = 1'b0;
            #1;
            chk("tbl_tready", tready, tbl[i].rdy);
            @(posedge clk); #1;
            chk("tbl_data", data, tbl[i].dat);
            chk("tbl_href", href, tbl[i].hrf);
            chk("tbl_vsync", vsync, tbl[i].vsy);
        end
        @(posedge clk); #1;
        chk("tbl_idle_data", data, 8'h00);
        chk("tbl_underrun", und, CNT_EN ? 8 : 0);
        chk("tbl_frames", fcnt, CNT_EN ? 1 : 0);

        // Model-checked sequences start from a clean reset
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        pos = -1; e_dat = 8'h00; e_href = 1'b0; e_vs = 1'b0; m_und = 0; m_serr = 0; m_frm = 0;
        run(3);

        // Full frame of well-formed beats, single frame then idle
        do_reset(); bq.delete(); vld_pct = 100;
        push_frame(1'b0, -1);
        en = 1'b1; run(1); en = 1'b0; run(FL + 3);
        chk("full_frame_frames", fcnt, CNT_EN ? 1 : 0);
        chk("full_frame_serr", serr, 0);
        chk("full_frame_underrun", und, 0);

        // Stale beats ahead of the start-of-frame beat are flushed in vertical blanking
        do_reset(); bq.delete();
        push_junk(3); push_frame(1'b0, -1);
        en = 1'b1; run(1); en = 1'b0; run(FL + 3);
        chk("flush_serr", serr, 0);
        chk("flush_frames", fcnt, CNT_EN ? 1 : 0);

        // Spurious tlast on pixel index 2 of the first active line
        do_reset(); bq.delete();
        push_frame(1'b0, 2);
        en = 1'b1; run(1); en = 1'b0; run(FL + 3);
        chk("tlast_err_serr", serr, CNT_EN ? 1 : 0);

        // Enable dropped mid-frame: frame completes, then idle
        do_reset(); bq.delete();
        push_frame(1'b0, -1);
        en = 1'b1; run(30); en = 1'b0; run(FL);
        chk("en_drop_idle_data", data, 8'h00);
        chk("en_drop_frames", fcnt, CNT_EN ? 1 : 0);

        // Reset mid-line with underruns accumulated, then restart
        do_reset(); bq.delete(); vld_pct = 50;
        push_frame(1'b0, -1);
        en = 1'b1; run(LL + 15);
        rst = 1'b1; drive(); tick(); rst = 1'b0;
        chk("midline_rst_data", data, 8'h00);
        chk("midline_rst_tready", tready, 1'b0);
        chk("midline_rst_counters", {und, serr}, 32'h0);
        bq.delete(); vld_pct = 100;
        push_frame(1'b0, -1);
        run(1); en = 1'b0; run(FL + 3);

        // Randomized frames
        for (int it = 0; it < 12; it++) begin
            vld_pct = int'($urandom_range(40, 100));
            if ($urandom_range(0, 2) == 0) push_junk(int'($urandom_range(1, 3)));
            if (bq.size() < 40)
                push_frame(1'b1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, HA - 1)) : -1);
            en = ($urandom_range(0, 3) != 0);
            run(int'($urandom_range(FL / 2, 2 * FL)));
            if ($urandom_range(0, 5) == 0) begin
                rst = 1'b1; drive(); tick(); rst = 1'b0;
            end
        end
        en = 1'b0;
        run(2 * FL);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
